// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative radix-2 shift-add sequencer for the RV32M multiply group
module mul_sequencer #(
    parameter int         XLEN        = 32,
    parameter bit         ZERO_BYPASS = 1'b1,
    parameter logic [3:0] ALU_MUL     = 4'd10,
    parameter logic [3:0] ALU_MULH    = 4'd11,
    parameter logic [3:0] ALU_MULHSU  = 4'd12,
    parameter logic [3:0] ALU_MULHU   = 4'd13
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [3:0]      alu_op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    input  logic            result_ready_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q;
    logic [2*XLEN-1:0] acc_q, mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [3:0]        op_q;
    logic              sign_q;

    logic              is_mul_op, valid_req, accept, bypass, finish;
    logic              a_signed, b_signed, sign_new, zero_operand;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] acc_sum, product;

    // Operand decode: magnitudes are unsigned so the most negative value fits.
    always_comb begin
        is_mul_op    = (alu_op_i == ALU_MUL) || (alu_op_i == ALU_MULH) ||
                       (alu_op_i == ALU_MULHSU) || (alu_op_i == ALU_MULHU);
        valid_req    = start_i && is_mul_op;
        a_signed     = (alu_op_i == ALU_MUL) || (alu_op_i == ALU_MULH) || (alu_op_i == ALU_MULHSU);
        b_signed     = (alu_op_i == ALU_MUL) || (alu_op_i == ALU_MULH);
        mag_a        = (a_signed && op_a_i[XLEN-1]) ? -op_a_i : op_a_i;
        mag_b        = (b_signed && op_b_i[XLEN-1]) ? -op_b_i : op_b_i;
        sign_new     = (a_signed && op_a_i[XLEN-1]) ^ (b_signed && op_b_i[XLEN-1]);
        zero_operand = (op_a_i == '0) || (op_b_i == '0);
        acc_sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        product      = sign_q ? -acc_sum : acc_sum;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        bypass  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_req) begin
                    if (ZERO_BYPASS && zero_operand) begin
                        state_d = DONE;
                        bypass  = 1'b1;
                    end else begin
                        state_d = CALC;
                        accept  = 1'b1;
                    end
                end
            end
            CALC: begin
                if (count_q == LAST) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides every transition, including a same-cycle consume.
        if (flush_i) begin
            state_d = IDLE;
            accept  = 1'b0;
            bypass  = 1'b0;
            finish  = 1'b0;
        end
        stall_o        = ((state_q == IDLE) && valid_req && !flush_i) || (state_q == CALC);
        busy_o         = (state_q != IDLE);
        result_valid_o = (state_q == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            result_o <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else if (accept) begin
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= {{XLEN{1'b0}}, mag_a};
            mplier_q <= mag_b;
            op_q     <= alu_op_i;
            sign_q   <= sign_new;
        end else if (bypass) begin
            op_q     <= alu_op_i;
            result_o <= '0;
        end else if (state_q == CALC) begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CW'(1);
            if (finish) begin
                result_o <= (op_q == ALU_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
            end
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - randomized and directed bench for mul_sequencer against an arithmetic model
module tb_mul_sequencer;
    localparam int         XLEN       = 32;
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_MUL    = 4'd10;
    localparam logic [3:0] ALU_MULH   = 4'd11;
    localparam logic [3:0] ALU_MULHSU = 4'd12;
    localparam logic [3:0] ALU_MULHU  = 4'd13;

    logic        clk, rst_n, start, flush, ready;
    logic [3:0]  alu_op;
    logic [31:0] op_a, op_b;
    logic        stall, busy, valid;
    logic [31:0] result;
    int          total, bad;

    mul_sequencer dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .alu_op_i      (alu_op),
        .op_a_i        (op_a),
        .op_b_i        (op_b),
        .flush_i       (flush),
        .result_ready_i(ready),
        .stall_o       (stall),
        .busy_o        (busy),
        .result_valid_o(valid),
        .result_o      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full-width product from integer arithmetic, then the requested half.
    function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] ua, ubu, p;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        ua  = {32'b0, a};
        ubu = {32'b0, b};
        case (op)
            ALU_MUL, ALU_MULH: p = sa * sb;
            ALU_MULHSU:        p = sa * ub;
            default:           p = ua * ubu;
        endcase
        return (op == ALU_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold, input string tag);
        int          lat, cyc, stalls;
        logic [31:0] held;
        lat = (a == 0 || b == 0) ? 1 : XLEN + 1;
        @(negedge clk);
        start = 1'b1; alu_op = op; op_a = a; op_b = b;
        #1;
        stalls = stall ? 1 : 0;
        @(negedge clk);
        cyc = 1;
        start = 1'b0; alu_op = $urandom_range(0, 15); op_a = $urandom; op_b = $urandom;
        while (!valid && cyc < 100) begin
            stalls += stall ? 1 : 0;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, lat);
        check({tag, " stall cycles"}, stalls, lat);
        check({tag, " result"}, result, exp);
        held = result;
        for (int i = 0; i < hold; i++) begin
            start = 1'b1; alu_op = ALU_MUL + 4'($urandom_range(0, 3)); op_a = $urandom; op_b = $urandom;
            #1;
            check({tag, " done stall"}, stall, 1'b0);
            @(negedge clk);
            check({tag, " held valid"}, valid, 1'b1);
            check({tag, " held result"}, result, held);
        end
        start = 1'b0; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check({tag, " idle after ready"}, {busy, valid}, 2'b00);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic        saw_valid;
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; ready = 1'b0;
        alu_op = ALU_ADD; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", {stall, busy, valid, result}, 35'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5, "mul 7*-3");
        do_op(ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, "mulh min*min");
        do_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu max*max");
        do_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0, "mulhsu -1*2");
        do_op(ALU_MUL, 32'h0, 32'h1234, 32'h0, 2, "mul bypass");

        for (int n = 0; n < 20; n++) begin
            rop = ALU_MUL + 4'($urandom_range(0, 3));
            ra  = rand_operand();
            rb  = rand_operand();
            do_op(rop, ra, rb, ref_mul(rop, ra, rb), $urandom_range(0, 3), "random");
        end

        // Flush mid-calculation at count 10.
        @(negedge clk);
        start = 1'b1; alu_op = ALU_MUL; op_a = 32'd5; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("busy before flush", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush to idle", {busy, valid, stall}, 3'b000);
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_valid |= valid;
        end
        check("no valid after flush", saw_valid, 1'b0);

        // Flush blocks acceptance in IDLE.
        start = 1'b1; alu_op = ALU_MULH; op_a = 32'd3; op_b = 32'd4; flush = 1'b1;
        #1;
        check("flush+start stall", stall, 1'b0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush+start no accept", busy, 1'b0);

        // Flush together with ready in DONE.
        @(negedge clk);
        start = 1'b1; alu_op = ALU_MUL; op_a = 32'd0; op_b = 32'd8;
        @(negedge clk);
        start = 1'b0;
        check("bypass done", valid, 1'b1);
        flush = 1'b1; ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; ready = 1'b0;
        check("flush+ready idle", {busy, valid}, 2'b00);

        // Non-multiply ops are ignored.
        for (int n = 0; n < 4; n++) begin
            start = 1'b1; alu_op = (n == 0) ? ALU_ADD : 4'($urandom_range(0, 9)); op_a = $urandom | 1; op_b = $urandom | 1;
            #1;
            check("non-mul stall", stall, 1'b0);
            @(negedge clk);
            check("non-mul idle", busy, 1'b0);
        end
        start = 1'b0;

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; alu_op = ALU_MULHU; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("calc before reset", {busy, stall}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", {stall, busy, valid, result}, 35'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_valid |= valid | busy;
        end
        check("no residual after reset", saw_valid, 1'b0);

        do_op(ALU_MUL, 32'h8000_0000, 32'hFFFF_FFFF, ref_mul(ALU_MUL, 32'h8000_0000, 32'hFFFF_FFFF), 1, "post-reset mul");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
